// File: rtl/wb_cmd_initiator_if.sv
// wb_cmd_initiator_if
//   Bundles the command/response port and the Wishbone pipelined bus of
//   wb_cmd_initiator. Signal names keep the _i/_o suffixes as seen from the
//   initiator, so the RTL reads the same as the block's port list.
//
//   modport master : the initiator's view (takes commands, drives the bus)
//   modport slave  : the environment's view (issues commands, answers the bus)
//
//   Command side : req_valid_i, req_ready_o, req_we_i, req_adr_i, req_sel_i,
//                  req_dat_i, rsp_valid_o, rsp_status_o, rsp_dat_o
//   Bus side     : wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
//                  wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
interface wb_cmd_initiator_if #(
    parameter int ADDR_WIDTH = 4
) ();
    // command / response
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [ADDR_WIDTH-1:0] req_adr_i;
    logic [3:0]            req_sel_i;
    logic [31:0]           req_dat_i;
    logic                  rsp_valid_o;
    logic [1:0]            rsp_status_o;
    logic [31:0]           rsp_dat_o;

    // Wishbone pipelined bus; address is the word address [ADDR_WIDTH+1:2]
    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [ADDR_WIDTH+1:2] wb_adr_o;
    logic [3:0]            wb_sel_o;
    logic [31:0]           wb_dat_o;
    logic                  wb_ack_i;
    logic                  wb_err_i;
    logic                  wb_rty_i;
    logic                  wb_stall_i;
    logic [31:0]           wb_dat_i;

    modport master (
        input  req_valid_i, req_we_i, req_adr_i, req_sel_i, req_dat_i,
        output req_ready_o, rsp_valid_o, rsp_status_o, rsp_dat_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        input  wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
    );

    modport slave (
        output req_valid_i, req_we_i, req_adr_i, req_sel_i, req_dat_i,
        input  req_ready_o, rsp_valid_o, rsp_status_o, rsp_dat_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        output wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
    );
endinterface

// File: rtl/wb_cmd_initiator.sv
// wb_cmd_initiator
//   Wishbone pipelined initiator: each accepted single-word command becomes
//   one bus cycle; the result comes back as a one-cycle rsp_valid_o strobe.
//   One transaction outstanding at a time. Handles stall, err, rty (with
//   bounded re-issue through a one-cycle cyc-low gap) and ack.
//
//   Optional feature: define WB_CMD_INITIATOR_TIMEOUT_EN to abort an attempt
//   that sees no termination within TIMEOUT cycles (status 11). Without it
//   the initiator waits indefinitely.
//
//   Parameters: ADDR_WIDTH (word-address bits), TIMEOUT (>=1),
//               MAX_RETRY (re-issues allowed after rty)
//   Ports:
//     clk_i    rising-edge clock
//     rst_n_i  asynchronous active-low reset
//     bus      wb_cmd_initiator_if.master (command port + Wishbone bus)
//   Response status: 00 ok, 01 err, 10 retry exhausted, 11 timeout.
module wb_cmd_initiator #(
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 255,
    parameter int MAX_RETRY  = 3
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    wb_cmd_initiator_if.master  bus
);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_RTY = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("wb_cmd_initiator: TIMEOUT must be >= 1");
    end
    if (MAX_RETRY < 0) begin : g_bad_retry
        $error("wb_cmd_initiator: MAX_RETRY must be >= 0");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t                state_q, state_d;

    // latched command, held on the bus until the next accept
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [3:0]            sel_q;
    logic [31:0]           dat_q;

    logic                  rsp_valid_q;
    logic [1:0]            rsp_status_q;
    logic [31:0]           rsp_dat_q;
    logic [RTY_W-1:0]      rty_cnt_q;

    logic                  accept;
    logic                  sample;
    logic                  done;
    logic [1:0]            done_status;
    logic                  cap_dat;
    logic                  rty_inc;
    logic                  tmo_hit;

    assign accept = (state_q == IDLE) && bus.req_valid_i;

    // Terminations only count once the strobe has been taken: in REQ with
    // no stall, or anywhere in WAIT. A stalled strobe ignores them.
    assign sample = ((state_q == REQ) && !bus.wb_stall_i) || (state_q == WAIT);

`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_q;

    // Held at zero in IDLE/GAP so every attempt starts from zero on REQ
    // entry; counts each cycle the bus is owned.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt_q <= '0;
        end else if ((state_q == REQ) || (state_q == WAIT)) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign tmo_hit = ((state_q == REQ) || (state_q == WAIT)) &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT));
`else
    assign tmo_hit = 1'b0;
`endif

    // Next state and completion decode. Priority: err > rty > ack > timeout,
    // so a termination in the timeout cycle still wins.
    always_comb begin
        state_d     = state_q;
        done        = 1'b0;
        done_status = ST_OK;
        cap_dat     = 1'b0;
        rty_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) state_d = REQ;
            end
            REQ, WAIT: begin
                if (sample && bus.wb_err_i) begin
                    done        = 1'b1;
                    done_status = ST_ERR;
                end else if (sample && bus.wb_rty_i) begin
                    if (rty_cnt_q < RTY_W'(MAX_RETRY)) begin
                        rty_inc = 1'b1;
                        state_d = GAP;
                    end else begin
                        done        = 1'b1;
                        done_status = ST_RTY;
                    end
                end else if (sample && bus.wb_ack_i) begin
                    done    = 1'b1;
                    cap_dat = !we_q;
                end else if (tmo_hit) begin
                    done        = 1'b1;
                    done_status = ST_TMO;
                end else if (sample) begin
                    // strobe taken in REQ -> WAIT; WAIT keeps waiting
                    state_d = WAIT;
                end
                if (done) state_d = IDLE;
            end
            GAP: begin
                state_d = REQ;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            adr_q        <= '0;
            sel_q        <= '0;
            dat_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= ST_OK;
            rsp_dat_q    <= '0;
            rty_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= done;
            if (accept) begin
                we_q      <= bus.req_we_i;
                adr_q     <= bus.req_adr_i;
                sel_q     <= bus.req_sel_i;
                dat_q     <= bus.req_dat_i;
                rty_cnt_q <= '0;
            end else begin
                if (done)    we_q      <= 1'b0;
                if (rty_inc) rty_cnt_q <= rty_cnt_q + 1'b1;
            end
            if (done)    rsp_status_q <= done_status;
            if (cap_dat) rsp_dat_q    <= bus.wb_dat_i;
        end
    end

    // Ready is gated by reset so every output reads 0 while reset is held;
    // it rises in the same cycle as rsp_valid_o, allowing back-to-back use.
    assign bus.req_ready_o  = rst_n_i && (state_q == IDLE);
    assign bus.rsp_valid_o  = rsp_valid_q;
    assign bus.rsp_status_o = rsp_status_q;
    assign bus.rsp_dat_o    = rsp_dat_q;

    // cyc/stb decode straight from the state so reset drops them at once.
    assign bus.wb_cyc_o = (state_q == REQ) || (state_q == WAIT);
    assign bus.wb_stb_o = (state_q == REQ);
    assign bus.wb_we_o  = we_q;
    assign bus.wb_adr_o = adr_q;
    assign bus.wb_sel_o = sel_q;
    assign bus.wb_dat_o = dat_q;
endmodule

// File: tb/tb_wb_cmd_initiator.sv
// tb_wb_cmd_initiator
//   Scoreboard bench: each issued command pushes its expected {status, data}
//   and the monitor pops it on rsp_valid_o. A behavioural register-bank
//   slave answers one cycle after taking the strobe and can be told to
//   stall, answer rty, answer ack+err together, or stay silent.
module tb_wb_cmd_initiator;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_cmd_initiator_if #(.ADDR_WIDTH(AW)) bus ();

    wb_cmd_initiator #(.ADDR_WIDTH(AW), .TIMEOUT(8), .MAX_RETRY(3)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // scoreboard and shared bench state
    logic [33:0] exp_q[$];
    logic [31:0] mem [16];
    int  cyc_n = 0;
    int  stall_left = 0, rty_left = 0, tr_rty = 0;
    bit  silent = 0, both = 0, force_ack = 0, pending = 0;
    bit  last_final = 0, prev_rsp = 0, busy = 0;
    int  stb_cycles = 0, adr_moved = 0, gap_cycles = 0, rsp_n = 0;
    int  accept_cyc = 0, rsp_cyc = 0;
    logic rsp_cyc_o = 1'b0;
    logic [3:0]  exp_adr = '0;
    logic [31:0] last_dat = '0;

    always @(posedge clk) cyc_n++;

    // Monitor + slave, evaluated away from the active edge.
    always @(negedge clk) begin
        logic [33:0] e;
        // monitor
        if (last_final) chk("latency", bus.rsp_valid_o, 1'b1);
        if (prev_rsp)   chk("pulse_len", bus.rsp_valid_o, 1'b0);
        if (bus.rsp_valid_o) begin
            chk("ready_with_rsp", bus.req_ready_o, 1'b1);
            if (exp_q.size() == 0) begin
                chk("spurious_rsp", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("status", bus.rsp_status_o, e[33:32]);
                chk("rsp_dat", bus.rsp_dat_o, e[31:0]);
            end
            busy = 0;
            rsp_cyc = cyc_n;
            rsp_cyc_o = bus.wb_cyc_o;
            rsp_n++;
        end
        if (busy && !bus.wb_cyc_o && !bus.rsp_valid_o) gap_cycles++;
        prev_rsp = bus.rsp_valid_o;

        // slave: terminate the strobe taken at the previous edge
        bus.wb_ack_i = force_ack;
        bus.wb_err_i = 1'b0;
        bus.wb_rty_i = 1'b0;
        bus.wb_dat_i = 32'h0;
        last_final = 0;
        if (pending) begin
            pending = 0;
            if (bus.wb_cyc_o) begin
                if (rty_left > 0) begin
                    bus.wb_rty_i = 1'b1;
                    rty_left--;
                    tr_rty++;
                    last_final = (tr_rty > 3);
                end else if (silent) begin
                    last_final = 0;
                end else if (both) begin
                    bus.wb_ack_i = 1'b1;
                    bus.wb_err_i = 1'b1;
                    last_final = 1;
                end else begin
                    bus.wb_ack_i = 1'b1;
                    last_final = 1;
                    if (bus.wb_we_o) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.wb_sel_o[b]) mem[bus.wb_adr_o][b*8 +: 8] = bus.wb_dat_o[b*8 +: 8];
                    end else begin
                        bus.wb_dat_i = mem[bus.wb_adr_o];
                    end
                end
            end
        end
        // slave: stall or take the strobe at the coming edge
        bus.wb_stall_i = 1'b0;
        if (bus.wb_stb_o) begin
            stb_cycles++;
            if (bus.wb_adr_o != exp_adr) adr_moved++;
            if (stall_left > 0) begin
                bus.wb_stall_i = 1'b1;
                stall_left--;
            end else begin
                pending = 1;
            end
        end
    end

    task automatic issue(input bit we, input logic [3:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input logic [1:0] st,
                         input logic [31:0] edat, input bit exp_rsp);
        int n;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_adr_i   = adr;
        bus.req_sel_i   = sel;
        bus.req_dat_i   = dat;
        n = 0;
        while (!bus.req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", bus.req_ready_o, 1'b1);
        exp_adr = adr;
        tr_rty = 0;
        stb_cycles = 0;
        adr_moved = 0;
        gap_cycles = 0;
        if (exp_rsp) exp_q.push_back({st, edat});
        @(posedge clk);
        #1;
        accept_cyc = cyc_n;
        busy = 1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_seen", busy, 1'b0);
    endtask

    initial begin
        int n0, a1;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_adr_i   = '0;
        bus.req_sel_i   = '0;
        bus.req_dat_i   = '0;

        // reset values
        #12;
        chk("reset_outs", {bus.req_ready_o, bus.rsp_valid_o, bus.rsp_status_o, bus.rsp_dat_o,
                           bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o,
                           bus.wb_sel_o, bus.wb_dat_o}, 128'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // write then read back word 8
        issue(1, 4'd8, 4'hf, 32'hDEADBEEF, 2'b00, 32'h0, 1);
        wait_rsp();
        issue(0, 4'd8, 4'hf, 32'h0, 2'b00, 32'hDEADBEEF, 1);
        wait_rsp();
        last_dat = 32'hDEADBEEF;

        // back-to-back: one bus cycle every 3 clocks
        issue(1, 4'd1, 4'hf, 32'hA5A5A5A5, 2'b00, last_dat, 1);
        a1 = accept_cyc;
        issue(1, 4'd2, 4'hf, 32'h0F0F0F0F, 2'b00, last_dat, 1);
        chk("b2b_spacing", accept_cyc - a1, 3);
        wait_rsp();
        issue(0, 4'd2, 4'hf, 32'h0, 2'b00, 32'h0F0F0F0F, 1);
        wait_rsp();
        last_dat = 32'h0F0F0F0F;

        // 5 stall cycles on a partial write
        stall_left = 5;
        issue(1, 4'd3, 4'b0011, 32'h12345678, 2'b00, last_dat, 1);
        wait_rsp();
        chk("stb_cycles", stb_cycles, 6);
        chk("adr_stable", adr_moved, 0);
        issue(0, 4'd3, 4'hf, 32'h0, 2'b00, 32'h00005678, 1);
        wait_rsp();
        last_dat = 32'h00005678;

        // three rty then ack
        rty_left = 3;
        issue(0, 4'd8, 4'hf, 32'h0, 2'b00, 32'hDEADBEEF, 1);
        wait_rsp();
        chk("gap_cycles_rty3", gap_cycles, 3);
        last_dat = 32'hDEADBEEF;

        // four rty: retry exhausted, read data left alone
        rty_left = 4;
        issue(0, 4'd3, 4'hf, 32'h0, 2'b10, last_dat, 1);
        wait_rsp();
        chk("gap_cycles_rty4", gap_cycles, 3);

        // ack and err together: err wins
        both = 1;
        issue(0, 4'd3, 4'hf, 32'h0, 2'b01, last_dat, 1);
        wait_rsp();
        both = 0;

        // silent slave
        silent = 1;
`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
        issue(0, 4'd5, 4'hf, 32'h0, 2'b11, last_dat, 1);
        wait_rsp();
        chk("tmo_latency", rsp_cyc - accept_cyc, 9);
        chk("tmo_cyc_low", rsp_cyc_o, 1'b0);
        issue(0, 4'd5, 4'hf, 32'h0, 2'b11, last_dat, 0);
        repeat (3) @(negedge clk);
`else
        n0 = rsp_n;
        issue(0, 4'd5, 4'hf, 32'h0, 2'b11, last_dat, 0);
        repeat (1000) @(negedge clk);
        chk("no_rsp_1000", rsp_n - n0, 0);
`endif
        // reset in WAIT drops everything without waiting for an edge
        chk("in_wait", {bus.wb_cyc_o, bus.wb_stb_o}, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", {bus.req_ready_o, bus.rsp_valid_o, bus.rsp_status_o, bus.rsp_dat_o,
                                 bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o,
                                 bus.wb_sel_o, bus.wb_dat_o}, 128'h0);
        silent = 0;
        busy = 0;
        exp_q.delete();
        last_dat = 32'h0;
        n0 = rsp_n;
        @(negedge clk);
        @(negedge clk);
        chk("no_rsp_after_reset", rsp_n - n0, 0);
        rst_n = 1'b1;

        // normal read after release
        issue(0, 4'd8, 4'hf, 32'h0, 2'b00, 32'hDEADBEEF, 1);
        wait_rsp();

        // spurious ack while IDLE is ignored
        n0 = rsp_n;
        @(negedge clk);
        force_ack = 1;
        @(negedge clk);
        @(negedge clk);
        force_ack = 0;
        repeat (3) @(negedge clk);
        chk("idle_ack_ignored", rsp_n - n0, 0);
        chk("idle_cyc_low", bus.wb_cyc_o, 1'b0);
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wb_cmd_initiator.md
# wb_cmd_initiator

Wishbone pipelined initiator that turns single-word requests from a valid/ready command port into one bus cycle at a time. It drives the generated register-bank slaves from sequencers and debug bridges, handling stall, error, retry and timeout terminations, and returns each result on a one-cycle response strobe. Only one transaction is outstanding at any time.

## Interface
- `ADDR_WIDTH`, 4: word-address bits; the bus address is `[ADDR_WIDTH+1:2]`.
- `TIMEOUT`, 255: maximum cycles per attempt with `wb_cyc_o`=1 before abort; must be ≥1.
- `MAX_RETRY`, 3: number of re-issues allowed after `wb_rty_i`.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  command valid.
- `req_ready_o`  out  1  command accepted when `req_valid_i` and `req_ready_o` are both 1.
- `req_we_i`  in  1  1 = write, 0 = read.
- `req_adr_i`  in  ADDR_WIDTH  word address.
- `req_sel_i`  in  4  byte selects.
- `req_dat_i`  in  32  write data.
- `rsp_valid_o`  out  1  one-cycle response pulse.
- `rsp_status_o`  out  2  00 ok, 01 err, 10 retry exhausted, 11 timeout.
- `rsp_dat_o`  out  32  read data; holds `wb_dat_i` captured on ack.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each  Wishbone controls.
- `wb_adr_o`  out  [ADDR_WIDTH+1:2]  bus address.
- `wb_sel_o`  out  4  byte selects.
- `wb_dat_o`  out  32  write data.
- `wb_ack_i`, `wb_err_i`, `wb_rty_i`, `wb_stall_i`  in  1 each  slave terminations and stall.
- `wb_dat_i`  in  32  read data.

## Operation
- **Reset values:** every output is 0, the state is IDLE, and the counters are 0.
- **State IDLE**
  - `req_ready_o`=1.
  - On accept, latch we, adr, sel and dat into the `wb_*_o` registers, clear the retry counter, and go to REQ.
- **State REQ**
  - `wb_cyc_o`=1 and `wb_stb_o`=1.
  - If `wb_stall_i`=0, the strobe is accepted.
  - If a termination is also present in that cycle, complete; otherwise go to WAIT.
  - If `wb_stall_i`=1, stay in REQ.
- **State WAIT**
  - `wb_cyc_o`=1 and `wb_stb_o`=0.
  - Wait for a termination.
- **State GAP**
  - `wb_cyc_o`=0 for exactly one cycle, then go to REQ.
- **Termination priority:** `wb_err_i` > `wb_rty_i` > `wb_ack_i`. Terminations are sampled only when `wb_cyc_o`=1; they are ignored in IDLE and GAP.
  - ack: status 00, capture `rsp_dat_o` (reads only; writes leave `rsp_dat_o` unchanged).
  - err: status 01.
  - rty with retry count < MAX_RETRY: increment the count, go to GAP, no response.
  - rty with retry count = MAX_RETRY: status 10.
- **Completion:** on the next edge `wb_cyc_o`, `wb_stb_o` and `wb_we_o` go to 0, `rsp_valid_o`=1 for one cycle with status, and the state returns to IDLE.
- **Address and data hold:** `wb_adr_o`, `wb_sel_o` and `wb_dat_o` hold their values until the next accept.
- **Counter widths:** the retry counter is `$clog2(MAX_RETRY+1)` bits; the timeout counter is `$clog2(TIMEOUT+1)` bits.

## Timing
- **Accept at edge N:** `wb_stb_o` is high from cycle N+1.
- **Back-to-back:** `req_ready_o` is high in the same cycle as `rsp_valid_o`, so a new command may be accepted then. Minimum spacing is one bus cycle every 3 clocks against a zero-wait slave.
- **Latency:** `rsp_valid_o` is asserted exactly 1 cycle after the termination is sampled.
- **Stall:** `wb_stb_o` stays high while `wb_stall_i`=1, with address and data stable.
- **Asynchronous reset mid-cycle:** `wb_cyc_o` and `wb_stb_o` drop immediately and no response is generated.

## Configuration
- Macro `WB_CMD_INITIATOR_TIMEOUT_EN`.
- **Defined:**
  - The timeout counter clears on entry to REQ from IDLE or GAP and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT with no termination, the initiator completes with status 11.
  - A termination arriving in that same cycle wins over the timeout.
- **Undefined:** there is no counter; the initiator waits indefinitely and status 11 is never produced.

## Test plan
- Zero-wait register-bank slave, write 0xDEADBEEF to word 8, then read word 8 → two responses, both status 00, with `rsp_dat_o`=0xDEADBEEF.
- Slave holds `wb_stall_i`=1 for 5 cycles → `wb_stb_o` is high for 6 cycles with `wb_adr_o` stable, then status 00.
- Slave answers rty three times then ack, with MAX_RETRY=3 → three GAP cycles with `wb_cyc_o`=0, status 00. Four rty answers → status 10.
- Slave asserts ack and err together → status 01.
- Macro defined, TIMEOUT=8, slave silent → `rsp_valid_o` with status 11 and `wb_cyc_o` low 9 cycles after the accept. Macro undefined → no response after 1000 cycles.
- Reset asserted in WAIT → all outputs 0 asynchronously. After release, a read completes normally and a spurious ack while IDLE produces no response.
